// File: rtl/clic_gateway.sv
// CLIC interrupt gateway: synchronizes raw interrupt lines, applies the
// per-source trigger polarity and mode, and produces clicintip hardware
// write data/enable. Edge sources set on an active edge and clear on a claim;
// level sources track the polarity-adjusted line. All sources run in parallel.

module clic_gateway_lane (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       intr_i,
    input  logic [1:0] trig_i,
    input  logic       ip_q_i,
    input  logic       warm_done_i,
    input  logic       claim_hit_i,
    output logic       ip_d_o,
    output logic       ip_de_o
);

    logic s1_q, s1_d;
    logic s2_q, s2_d;
    logic prev_q, prev_d;
    logic ip_d_q, ip_d_d;
    logic ip_de_q, ip_de_d;
    logic adj, adj_prev, edge_evt;

    // Synchronizer, history flop and registered hw2reg outputs
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            s1_q    <= 1'b0;
            s2_q    <= 1'b0;
            prev_q  <= 1'b0;
            ip_d_q  <= 1'b0;
            ip_de_q <= 1'b0;
        end else begin
            s1_q    <= s1_d;
            s2_q    <= s2_d;
            prev_q  <= prev_d;
            ip_d_q  <= ip_d_d;
            ip_de_q <= ip_de_d;
        end
    end

    // Polarity is applied to both the current and history sample with the
    // same trig bit, so flipping polarity can never look like an edge.
    always_comb begin
        s1_d     = intr_i;
        s2_d     = s1_q;
        prev_d   = s2_q;
        adj      = s2_q ^ trig_i[1];
        adj_prev = prev_q ^ trig_i[1];
        edge_evt = trig_i[0] & adj & ~adj_prev & warm_done_i;
        ip_d_d   = 1'b0;
        ip_de_d  = 1'b0;
        if (trig_i[0]) begin
            // Edge mode: a new edge wins over a simultaneous claim
            if (edge_evt) begin
                ip_d_d  = 1'b1;
                ip_de_d = 1'b1;
            end else if (claim_hit_i) begin
                ip_d_d  = 1'b0;
                ip_de_d = 1'b1;
            end
        end else begin
            // Level mode: only write when the pending bit disagrees with the line
            if (warm_done_i && (adj != ip_q_i)) begin
                ip_d_d  = adj;
                ip_de_d = 1'b1;
            end
        end
    end

    assign ip_d_o  = ip_d_q;
    assign ip_de_o = ip_de_q;

endmodule

module clic_gateway #(
    parameter int NumSrc = 256,
    parameter int IdW    = $clog2(NumSrc)
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic [NumSrc-1:0]   intr_src_i,
    input  logic [2*NumSrc-1:0] trig_i,
    input  logic [NumSrc-1:0]   ip_q_i,
    input  logic                claim_valid_i,
    input  logic [IdW-1:0]      claim_id_i,
    output logic [NumSrc-1:0]   ip_d_o,
    output logic [NumSrc-1:0]   ip_de_o
);

    logic [1:0]        warm_cnt_q, warm_cnt_d;
    logic              warm_done;
    logic [NumSrc-1:0] claim_hit;

    // Warm-up counter: saturates at 3, restarts on every reset
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            warm_cnt_q <= 2'd0;
        end else begin
            warm_cnt_q <= warm_cnt_d;
        end
    end

    // Count up until saturation; updates are gated until the count is full
    always_comb begin
        warm_cnt_d = (warm_cnt_q == 2'd3) ? 2'd3 : warm_cnt_q + 2'd1;
        warm_done  = (warm_cnt_q == 2'd3);
    end

    // One decoded claim per cycle. IDs at or above NumSrc match no lane and
    // are therefore dropped without any extra range check.
    for (genvar i = 0; i < NumSrc; i++) begin : g_lane
        assign claim_hit[i] = claim_valid_i && (claim_id_i == IdW'(i));

        clic_gateway_lane u_lane (
            .clk_i       (clk_i),
            .rst_i       (rst_i),
            .intr_i      (intr_src_i[i]),
            .trig_i      (trig_i[2*i +: 2]),
            .ip_q_i      (ip_q_i[i]),
            .warm_done_i (warm_done),
            .claim_hit_i (claim_hit[i]),
            .ip_d_o      (ip_d_o[i]),
            .ip_de_o     (ip_de_o[i])
        );
    end

endmodule

// File: tb/tb_clic_gateway.sv
// Bench for clic_gateway: directed scenarios plus randomized traffic checked
// against a sample-history reference model.

module tb_clic_gateway;

    localparam int N  = 12;
    localparam int IW = $clog2(N);

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    intr;
    logic [2*N-1:0]  trig;
    logic [N-1:0]    ip_q;
    logic            claim_v;
    logic [IW-1:0]   claim_id;
    logic [N-1:0]    ip_d, ip_de;

    int vecs = 0;
    int errs = 0;

    // Reference model: every sampled line vector is kept by edge number, and
    // the expected write at edge e is derived from the samples two and three
    // edges back, the inputs seen at e, and the distance to the last reset.
    logic [N-1:0] line_hist[$];
    int           edge_n   = 0;
    int           rst_edge = -100;
    logic [N-1:0] exp_d, exp_de;

    clic_gateway #(.NumSrc(N), .IdW(IW)) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .intr_src_i    (intr),
        .trig_i        (trig),
        .ip_q_i        (ip_q),
        .claim_valid_i (claim_v),
        .claim_id_i    (claim_id),
        .ip_d_o        (ip_d),
        .ip_de_o       (ip_de)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        line_hist.push_back(intr);
        if (rst) begin
            rst_edge = edge_n;
            exp_d    = '0;
            exp_de   = '0;
        end else begin
            for (int i = 0; i < N; i++) begin
                logic now_v, old_v, a, ap;
                bit   warm;
                now_v = (edge_n >= 2 && edge_n - 2 > rst_edge) ? line_hist[edge_n-2][i] : 1'b0;
                old_v = (edge_n >= 3 && edge_n - 3 > rst_edge) ? line_hist[edge_n-3][i] : 1'b0;
                warm  = (edge_n - rst_edge >= 4);
                a     = now_v ^ trig[2*i+1];
                ap    = old_v ^ trig[2*i+1];
                exp_d[i]  = 1'b0;
                exp_de[i] = 1'b0;
                if (trig[2*i]) begin
                    if (warm && a && !ap) begin
                        exp_d[i] = 1'b1; exp_de[i] = 1'b1;
                    end else if (claim_v && int'(claim_id) == i) begin
                        exp_de[i] = 1'b1;
                    end
                end else if (warm && a != ip_q[i]) begin
                    exp_d[i] = a; exp_de[i] = 1'b1;
                end
            end
        end
        edge_n++;
        #1;
    endtask

    function automatic logic [2*N-1:0] trig_cfg();
        logic [2*N-1:0] t;
        t = '0;
        for (int i = 0; i < N; i++) t[2*i] = 1'b1;  // edge, positive
        t[15] = 1'b1;                                // source 7 negative
        t[20] = 1'b0;                                // source 10 level
        return t;
    endfunction

    task automatic test_reset();
        rst = 1'b1; intr = 12'h080; trig = trig_cfg(); ip_q = '0;
        claim_v = 1'b0; claim_id = '0;
        repeat (3) step();
        vecs++;
        if (ip_d !== '0 || ip_de !== '0) begin
            errs++; $display("FAIL reset_outputs: d=%h de=%h, expected 0 0", ip_d, ip_de);
        end
        rst = 1'b0;
        repeat (5) begin
            step();
            vecs++;
            if (ip_de !== '0) begin
                errs++; $display("FAIL reset_quiet: de=%h, expected 0", ip_de);
            end
        end
    endtask

    task automatic test_edge_pos();
        intr[5] = 1'b1;
        repeat (2) begin
            step();
            vecs++;
            if (ip_de[5] !== 1'b0) begin
                errs++; $display("FAIL edge_pos_early: de5=%b, expected 0", ip_de[5]);
            end
        end
        step();
        vecs++;
        if (ip_d[5] !== 1'b1 || ip_de[5] !== 1'b1) begin
            errs++; $display("FAIL edge_pos_pulse: d5=%b de5=%b, expected 1 1", ip_d[5], ip_de[5]);
        end
        repeat (5) begin
            step();
            vecs++;
            if (ip_de[5] !== 1'b0) begin
                errs++; $display("FAIL edge_pos_single: de5=%b, expected 0", ip_de[5]);
            end
        end
    endtask

    task automatic test_edge_neg();
        intr[7] = 1'b0;
        repeat (2) begin
            step();
            vecs++;
            if (ip_de[7] !== 1'b0) begin
                errs++; $display("FAIL edge_neg_early: de7=%b, expected 0", ip_de[7]);
            end
        end
        step();
        vecs++;
        if (ip_d[7] !== 1'b1 || ip_de[7] !== 1'b1) begin
            errs++; $display("FAIL edge_neg_pulse: d7=%b de7=%b, expected 1 1", ip_d[7], ip_de[7]);
        end
        step();
        intr[7] = 1'b1;
        repeat (5) begin
            step();
            vecs++;
            if (ip_de[7] !== 1'b0) begin
                errs++; $display("FAIL edge_neg_rise: de7=%b, expected 0", ip_de[7]);
            end
        end
        for (int t = 0; t < 2; t++) begin
            trig[15] = ~trig[15];
            repeat (3) begin
                step();
                vecs++;
                if (ip_de[7] !== 1'b0) begin
                    errs++; $display("FAIL edge_neg_polflip: de7=%b, expected 0", ip_de[7]);
                end
            end
        end
    endtask

    task automatic test_claim();
        intr[3] = 1'b1;
        repeat (3) step();
        vecs++;
        if (ip_d[3] !== 1'b1 || ip_de[3] !== 1'b1) begin
            errs++; $display("FAIL claim_setup: d3=%b de3=%b, expected 1 1", ip_d[3], ip_de[3]);
        end
        claim_v = 1'b1; claim_id = 4'd3;
        step();
        claim_v = 1'b0;
        vecs++;
        if (ip_d[3] !== 1'b0 || ip_de[3] !== 1'b1) begin
            errs++; $display("FAIL claim_clear: d3=%b de3=%b, expected 0 1", ip_d[3], ip_de[3]);
        end
        intr[3] = 1'b0;
        repeat (3) step();
        intr[3] = 1'b1;
        repeat (2) step();
        claim_v = 1'b1; claim_id = 4'd3;
        step();
        claim_v = 1'b0;
        vecs++;
        if (ip_d[3] !== 1'b1 || ip_de[3] !== 1'b1) begin
            errs++; $display("FAIL claim_vs_edge: d3=%b de3=%b, expected 1 1", ip_d[3], ip_de[3]);
        end
        step();
        for (int k = 12; k < 16; k++) begin
            claim_v = 1'b1; claim_id = IW'(k);
            step();
            vecs++;
            if (ip_de !== '0) begin
                errs++; $display("FAIL claim_out_of_range: id=%0d de=%h, expected 0", k, ip_de);
            end
        end
        claim_v = 1'b0;
    endtask

    task automatic test_level();
        ip_q[10] = 1'b0; intr[10] = 1'b1;
        repeat (2) step();
        vecs++;
        if (ip_de[10] !== 1'b0) begin
            errs++; $display("FAIL level_early: de10=%b, expected 0", ip_de[10]);
        end
        repeat (2) begin
            step();
            vecs++;
            if (ip_d[10] !== 1'b1 || ip_de[10] !== 1'b1) begin
                errs++; $display("FAIL level_set: d10=%b de10=%b, expected 1 1", ip_d[10], ip_de[10]);
            end
        end
        ip_q[10] = 1'b1;
        step();
        vecs++;
        if (ip_de[10] !== 1'b0) begin
            errs++; $display("FAIL level_settled: de10=%b, expected 0", ip_de[10]);
        end
        intr[10] = 1'b0;
        repeat (3) step();
        vecs++;
        if (ip_d[10] !== 1'b0 || ip_de[10] !== 1'b1) begin
            errs++; $display("FAIL level_clear: d10=%b de10=%b, expected 0 1", ip_d[10], ip_de[10]);
        end
        ip_q[10] = 1'b0;
        claim_v = 1'b1; claim_id = 4'd10;
        step();
        claim_v = 1'b0;
        vecs++;
        if (ip_de[10] !== 1'b0) begin
            errs++; $display("FAIL level_claim: de10=%b, expected 0", ip_de[10]);
        end
    endtask

    task automatic test_reset_all_ones();
        intr = '1; ip_q = '0; rst = 1'b1;
        repeat (3) step();
        rst = 1'b0;
        for (int j = 1; j <= 3; j++) begin
            step();
            vecs++;
            if (ip_de !== '0) begin
                errs++; $display("FAIL warmup_quiet: cycle %0d de=%h, expected 0", j, ip_de);
            end
        end
        step();
        vecs++;
        if (ip_de !== 12'h400 || ip_d[10] !== 1'b1) begin
            errs++; $display("FAIL warmup_level: de=%h d10=%b, expected 400 1", ip_de, ip_d[10]);
        end
        repeat (3) begin
            step();
            vecs++;
            if ((ip_de & ~12'h400) !== '0) begin
                errs++; $display("FAIL warmup_edge: de=%h, expected 0 on edge sources", ip_de);
            end
        end
    endtask

    task automatic test_reset_midflight();
        intr = 12'h080; ip_q = '0;
        repeat (5) step();
        intr[5] = 1'b1;
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        vecs++;
        if (ip_d !== '0 || ip_de !== '0) begin
            errs++; $display("FAIL midflight_reset: d=%h de=%h, expected 0 0", ip_d, ip_de);
        end
        repeat (6) begin
            step();
            vecs++;
            if (ip_de[5] !== 1'b0) begin
                errs++; $display("FAIL midflight_pulse: de5=%b, expected 0", ip_de[5]);
            end
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 600; c++) begin
            rst      = ($urandom_range(0, 39) == 0);
            intr     = intr ^ N'($urandom & $urandom);
            if ($urandom_range(0, 9) == 0) trig = (2*N)'($urandom);
            ip_q     = N'($urandom);
            claim_v  = 1'($urandom);
            claim_id = IW'($urandom_range(0, 15));
            step();
            vecs++;
            if (ip_d !== exp_d || ip_de !== exp_de) begin
                errs++;
                $display("FAIL random_cycle %0d: d=%h de=%h, expected d=%h de=%h",
                         c, ip_d, ip_de, exp_d, exp_de);
            end
        end
        rst = 1'b0;
    endtask

    initial begin
        test_reset();
        test_edge_pos();
        test_edge_neg();
        test_claim();
        test_level();
        test_reset_all_ones();
        test_reset_midflight();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule

// File: doc/clic_gateway.md
CLIC_GATEWAY -- requirements
Module: clic_gateway

Interface
REQ-001 SHALL have parameter NumSrc, default 256, the number of interrupt sources (at least 2).
REQ-002 SHALL have parameter IdW, default $clog2(NumSrc), the width of the claim ID.
REQ-003 clk_i  in  1  single clock; all flops on rising edge.
REQ-004 rst_i  in  1  reset, synchronous and active-high.
REQ-005 intr_src_i  in  NumSrc  raw asynchronous interrupt lines.
REQ-006 trig_i  in  2*NumSrc  per-source clicintattr.trig: bit0 1=edge/0=level; bit1 1=negative (falling/low), 0=positive (rising/high).
REQ-007 ip_q_i  in  NumSrc  current clicintip register value.
REQ-008 claim_valid_i  in  1  the core acknowledges the interrupt named by claim_id_i.
REQ-009 claim_id_i  in  IdW  index of the acknowledged source.
REQ-010 ip_d_o  out  NumSrc  clicintip hardware write data (hw2reg.d).
REQ-011 ip_de_o  out  NumSrc  clicintip hardware write enable (hw2reg.de).

Function
REQ-012 Each source SHALL pass through a 2-flop synchronizer (s1, s2), followed by a history flop (prev) that captures s2.
REQ-013 Polarity SHALL be applied after synchronization: adj = s2 XOR trig[1], adj_prev = prev XOR trig[1], using the current trig[1] for both terms. A polarity change therefore never creates an edge.
REQ-014 Edge event: trig[0]=1 AND adj=1 AND adj_prev=0 AND warm-up done.
REQ-015 Edge mode, event: the registered outputs for that source SHALL be d=1, de=1 in the next cycle.
REQ-016 Edge mode, claim: claim_valid_i=1 with claim_id_i=i and no edge event on i SHALL give d=0, de=1 on i in the next cycle.
REQ-017 An edge event and a claim on the same source in the same cycle SHALL resolve with set priority: d=1, de=1.
REQ-018 Level mode (trig[0]=0): when adj differs from ip_q_i[i] and warm-up is done, the next cycle SHALL give d=adj, de=1; otherwise de=0.
REQ-019 Level mode SHALL ignore claims.
REQ-020 A claim with claim_id_i >= NumSrc SHALL be ignored.
REQ-021 Only one source SHALL be claimable per cycle.
REQ-022 With no event and no claim, a source SHALL output de=0; d is don't-care but is driven 0.
REQ-023 Latency: a line first sampled asserted at edge k SHALL produce d=1, de=1 visible from edge k+2 until edge k+3, for one cycle in edge mode.
REQ-024 Claim latency SHALL be 1 cycle: a claim sampled at edge c is visible on the outputs from edge c.
REQ-025 A warm-up counter (2 bit) SHALL suppress all edge and level updates for the first 3 cycles after reset deasserts. Sources already active during reset therefore produce no edge event; a level source is written on the 4th cycle.
REQ-026 A trig[0] change SHALL take effect in the same cycle, with no pending side effect.
REQ-027 All sources SHALL be processed in parallel, with no arbitration between sources.

Reset
REQ-028 While rst_i=1 at a clock edge, s1, s2, prev, the warm-up counter, ip_d_o and ip_de_o SHALL all clear to 0.
REQ-029 rst_i asserted mid-operation SHALL discard any in-flight edge: no de pulse is issued after the reset edge.
REQ-030 No output SHALL depend combinationally on any input.

Verification
REQ-031 Edge-positive source 5: intr low, then high sampled at edge k -> ip_d_o[5]=1, ip_de_o[5]=1 for exactly cycle k+2..k+3; no further pulse while the line stays high.
REQ-032 Edge-negative source 7: line falls 1->0 -> same single pulse; line rises -> no pulse. Toggling trig_i[7].bit1 while the line is stable -> no pulse.
REQ-033 Edge source 3 pending: claim_valid_i=1, claim_id_i=3 -> d=0, de=1 next cycle. Claim coinciding with a new edge event -> d=1, de=1. claim_id_i=NumSrc -> no de on any source.
REQ-034 Level-positive source 10, ip_q_i[10]=0: line high -> de=1, d=1 after 2 cycles, repeated each cycle until ip_q_i[10]=1, then de=0. Line low -> d=0, de=1. Claim on 10 -> no effect.
REQ-035 intr_src_i all ones held through reset, then reset released -> no de pulse on any edge source. Level sources with ip_q_i=0 get de=1 on the 4th cycle after release.
REQ-036 rst_i pulsed 1 cycle after an edge is sampled -> no de pulse on the outputs. All outputs read 0 the cycle after the reset edge.
